aes256_key_expand: RTL and testbench

AES-256 key-schedule engine that reads the round-constant ROM and turns a 256-bit cipher key into the 15 round keys of AES-256 (FIPS-197, Nk=8, Nr=14). It drives the ROM's `address`/`rd` port and consumes its registered 32-bit `rcon` word. It streams round keys 0..14, one 128-bit key per valid pulse, to the ECB cipher core's round-key store.

---
 rtl/aes256_key_expand_pkg.sv | 25 ++
 rtl/aes_sbox.sv | 9 +
 rtl/aes256_key_expand.sv | 112 +++++++++++
 tb/tb_aes256_key_expand.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/aes256_key_expand_pkg.sv
// aes256_key_expand_pkg: AES-256 key schedule constants, FSM encoding and S-box table.
package aes256_key_expand_pkg;
  localparam int AES_NK = 8;
  localparam int AES_NR = 14;
  typedef enum logic [1:0] {IDLE, EMIT, REQ, GEN} state_t;
  // Entry 0x00 sits in the top byte, so byte a lives at bit offset 8*(255-a).
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
endpackage

// File: rtl/aes_sbox.sv
// aes_sbox: combinational AES S-box lookup, one byte in, one byte out.
module aes_sbox
  import aes256_key_expand_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] s
);
  assign s = SBOX[{~a, 3'b000} +: 8];
endmodule

// File: rtl/aes256_key_expand.sv
// aes256_key_expand: streams the 15 AES-256 round keys, one word of the schedule per GEN cycle.
module aes256_key_expand
  import aes256_key_expand_pkg::*;
#(
  parameter int NK = AES_NK,
  parameter int NR = AES_NR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NK*32-1:0] key,
  output logic [3:0]       rcon_addr,
  output logic             rcon_rd,
  input  logic [31:0]      rcon,
  output logic             rk_valid,
  output logic [3:0]       rk_index,
  output logic [127:0]     round_key,
  output logic             busy,
  output logic             done
);
  localparam logic [5:0] LAST = 6'(4*(NR+1)-1);
  state_t state_q, state_d;
  logic [NK*32-1:0] win_q, win_d;
  logic [5:0] i_q, i_d;
  logic [127:0] rk_q, rk_d;
  logic [3:0] idx_q, idx_d;
  logic vld_q, vld_d, busy_q, busy_d, done_q, done_d;
  logic [31:0] last, sub_in, sub_out, temp, w_new;
  // Window holds w[i-8] in the top word and w[i-1] in the bottom word.
  assign last = win_q[31:0];
  assign sub_in = (i_q[2:0] == 3'd0) ? {last[23:0], last[31:24]} : last;
  for (genvar g = 0; g < 4; g++) begin : g_sub
    aes_sbox u_sbox (.a(sub_in[8*g +: 8]), .s(sub_out[8*g +: 8]));
  end
  assign temp = (i_q[2:0] == 3'd0) ? (sub_out ^ rcon) : (i_q[2:0] == 3'd4) ? sub_out : last;
  assign w_new = win_q[NK*32-1 -: 32] ^ temp;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      win_q   <= '0;
      i_q     <= '0;
      rk_q    <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      i_q     <= i_d;
      rk_q    <= rk_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    i_d     = i_q;
    rk_d    = rk_q;
    idx_d   = idx_q;
    vld_d   = 1'b0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = EMIT;
        win_d   = key;
        i_d     = 6'd8;
        rk_d    = key[NK*32-1 -: 128];
        idx_d   = 4'd0;
        vld_d   = 1'b1;
        busy_d  = 1'b1;
      end
      EMIT: begin
        state_d = REQ;
        rk_d    = win_q[127:0];
        idx_d   = 4'd1;
        vld_d   = 1'b1;
      end
      REQ: state_d = GEN;
      GEN: begin
        win_d = {win_q[NK*32-33:0], w_new};
        if (i_q[1:0] == 2'd3) begin
          rk_d  = {win_q[95:0], w_new};
          idx_d = i_q[5:2];
          vld_d = 1'b1;
        end
        if (i_q == LAST) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          i_d     = i_q + 6'd1;
          state_d = (i_q[2:0] == 3'd7) ? REQ : GEN;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    rcon_rd   = (state_q == REQ);
    rcon_addr = rcon_rd ? {1'b0, i_q[5:3]} : 4'd0;
  end
  assign rk_valid  = vld_q;
  assign rk_index  = idx_q;
  assign round_key = rk_q;
  assign busy      = busy_q;
  assign done      = done_q;
endmodule

// File: tb/tb_aes256_key_expand.sv
// tb_aes256_key_expand: scoreboard bench with an independent key-schedule model and a live rcon ROM.
module tb_aes256_key_expand;
  localparam logic [255:0] A3 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
  typedef struct {logic [3:0] idx; logic [127:0] rk; logic dn; int at;} exp_t;
  typedef struct {logic [255:0] key; int idx; logic [127:0] rk;} vec_t;
  logic clk = 0, rst = 1, start = 0;
  logic [255:0] key = '0;
  logic [31:0] rcon = '0;
  logic [3:0] rcon_addr, rk_index;
  logic rcon_rd, rk_valid, busy, done;
  logic [127:0] round_key;
  int cyc = 0, n_cmp = 0, n_bad = 0, rd_cnt = 0, mbase = 0;
  exp_t sb[$];
  exp_t e;
  vec_t vt[5];
  logic [7:0] bsb[256];
  logic [127:0] model_rk[15];
  logic [127:0] got[16];

  aes256_key_expand dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .rcon_addr(rcon_addr), .rcon_rd(rcon_rd), .rcon(rcon),
    .rk_valid(rk_valid), .rk_index(rk_index), .round_key(round_key),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rcv(input int n);
    return (n >= 1 && n <= 7) ? 8'(1 << (n - 1)) : 8'h00;
  endfunction

  // ROM output is garbage except in the cycle after a read.
  always @(posedge clk) rcon <= rcon_rd ? {rcv(int'(rcon_addr)), 24'h0} : $urandom();

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00, x = a, y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic init_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++)
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      bsb[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(input logic [31:0] x);
    return {bsb[x[31:24]], bsb[x[23:16]], bsb[x[15:8]], bsb[x[7:0]]};
  endfunction

  task automatic model(input logic [255:0] k);
    logic [31:0] w[60];
    logic [31:0] t;
    for (int j = 0; j < 8; j++) w[j] = k[255 - 32*j -: 32];
    for (int j = 8; j < 60; j++) begin
      t = w[j-1];
      if (j % 8 == 0) t = subw({t[23:0], t[31:24]}) ^ {rcv(j / 8), 24'h0};
      else if (j % 8 == 4) t = subw(t);
      w[j] = w[j-8] ^ t;
    end
    for (int r = 0; r < 15; r++) model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Call at a negedge; returns at the negedge after the accepting edge.
  task automatic launch(input logic [255:0] k);
    start = 1'b1;
    key = k;
    model(k);
    for (int r = 0; r < 15; r++) begin
      int j = 4*r + 3;
      sb.push_back('{idx: 4'(r), rk: model_rk[r], dn: (r == 14), at: cyc + 1 + ((r < 2) ? r : j + j/8 - 6)});
    end
    for (int r = 0; r < 16; r++) got[r] = 'x;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 300) begin
      n_bad++;
      $display("FAIL timeout: %0d round keys still pending, busy=%b", sb.size(), busy);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 128'(busy), 128'(0));
    chk({tag, "_done"}, 128'(done), 128'(0));
    chk({tag, "_rk_valid"}, 128'(rk_valid), 128'(0));
    chk({tag, "_rk_index"}, 128'(rk_index), 128'(0));
    chk({tag, "_round_key"}, round_key, 128'(0));
    chk({tag, "_rcon_rd"}, 128'(rcon_rd), 128'(0));
    chk({tag, "_rcon_addr"}, 128'(rcon_addr), 128'(0));
  endtask

  always @(negedge clk) begin
    if (rcon_rd) begin
      rd_cnt = rd_cnt + 1;
      chk("rcon_addr", 128'(rcon_addr), 128'(rd_cnt));
      chk("rcon_rd_cycle", 128'(cyc - mbase), 128'(9*rd_cnt - 8));
    end
    if (rk_valid) begin
      got[rk_index] = round_key;
      if (rk_index == 4'd0) begin
        mbase = cyc;
        rd_cnt = 0;
      end
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_rk: got index %0d key %h, none expected", rk_index, round_key);
      end else begin
        e = sb.pop_front();
        chk("rk_index", 128'(rk_index), 128'(e.idx));
        chk($sformatf("round_key%0d", e.idx), round_key, e.rk);
        chk($sformatf("done@rk%0d", e.idx), 128'(done), 128'(e.dn));
        chk($sformatf("busy@rk%0d", e.idx), 128'(busy), 128'(!e.dn));
        chk($sformatf("edge@rk%0d", e.idx), 128'(cyc), 128'(e.at));
      end
      if (done) chk("rcon_rd_count", 128'(rd_cnt), 128'(7));
    end
  end

  initial begin
    int b, n;
    init_sbox();
    vt[0] = '{A3, 0, 128'h603deb1015ca71be2b73aef0857d7781};
    vt[1] = '{A3, 1, 128'h1f352c073b6108d72d9810a30914dff4};
    vt[2] = '{A3, 2, 128'h9ba354118e6925afa51a8b5f2067fcde};
    vt[3] = '{A3, 14, 128'hfe4890d1e6188d0b046df344706c631e};
    vt[4] = '{256'h0, 2, 128'h62636363626363636263636362636363};
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    for (int v = 0; v < 5; v++) begin
      @(negedge clk);
      launch(vt[v].key);
      wait_idle();
      chk($sformatf("table%0d_rk%0d", v, vt[v].idx), got[vt[v].idx], vt[v].rk);
    end
    // Restart and key changes while busy must be ignored.
    @(negedge clk);
    launch(A3);
    key = ~A3;
    b = cyc;
    while (cyc < b + 9) @(negedge clk);
    start = 1'b1;
    key = {8{$urandom()}};
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (5) @(negedge clk);
    chk("ignored_start_idle", 128'(busy), 128'(0));
    // Asynchronous reset in the middle of an expansion.
    @(negedge clk);
    launch(A3);
    b = cyc;
    while (cyc < b + 19) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("midreset");
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(A3);
    wait_idle();
    chk("after_reset_rk0", got[0], vt[0].rk);
    chk("after_reset_rk14", got[14], vt[3].rk);
    // Back-to-back: second start in the cycle right after done.
    @(negedge clk);
    launch(A3);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_first_done", 128'(done), 128'(1));
    launch(256'h0);
    wait_idle();
    chk("b2b_second_rk2", got[2], vt[4].rk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
